// File: rtl/sobel_gcd_spi_pkg.sv
// Shared definitions for the sobel_gcd SPI master/slave pair: master FSM states
// and the register address map carried in the upper byte of each command word.
package sobel_gcd_spi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_e;

   localparam logic [7:0] REG_INIT  = 8'h10;
   localparam logic [7:0] REG_STOP  = 8'h11;
   localparam logic [7:0] REG_CALIB = 8'h12;
   localparam logic [7:0] REG_CHLIM = 8'h13;
   localparam logic [7:0] REG_VALID = 8'hAA;

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period timer for the SPI master: pulses tick_o on the last cycle of every
// CLK_DIV-cycle window while enabled, and restarts from zero whenever disabled.
module spi_master_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i || !en_i) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign tick_o = en_i && (r_cnt == CNT_MAX);

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// Word-oriented mode-0 SPI master for the sobel_gcd register port: one command word
// per CS frame, MSB first, full duplex, received word returned as a one-cycle response.
module sobel_gcd_spi_master
   import sobel_gcd_spi_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int CLK_DIV   = 4,
   parameter int CS_GAP    = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cmd_valid_i,
   input  logic [WORD_SIZE-1:0] cmd_data_i,
   output logic                 cmd_ready_o,
   output logic                 rsp_valid_o,
   output logic [WORD_SIZE-1:0] rsp_data_o,
   output logic                 busy_o,
   output logic                 spi_sck_o,
   output logic                 spi_cs_o,
   output logic                 spi_sdo_o,
   input  logic                 spi_sdi_i
);

   localparam int BIT_W = $clog2(WORD_SIZE + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 w_tick;
   logic                 w_clk_en;
   logic                 w_accept;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_hold_done;
   logic                 r_sck;
   logic                 r_cs;
   logic                 r_sdo;
   logic                 r_rsp_valid;
   logic [WORD_SIZE-1:0] r_rsp_data;
   logic [WORD_SIZE-1:0] r_tx_shift;
   logic [WORD_SIZE-1:0] r_rx_shift;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [CS_GAP-1:0]    r_gap;

   assign w_accept    = cmd_valid_i && (r_state == S_IDLE);
   assign w_clk_en    = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
   assign w_rise      = (r_state == S_SHIFT) && w_tick && !r_sck;
   assign w_fall      = (r_state == S_SHIFT) && w_tick && r_sck;
   assign w_hold_done = (r_state == S_HOLD) && w_tick;

   spi_master_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (w_clk_en),
      .tick_o  (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid_i) w_state_nxt = S_SETUP;
         S_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_fall && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_HOLD;
         S_HOLD:  if (w_tick) w_state_nxt = S_GAP;
         S_GAP:   if (r_gap[CS_GAP-1]) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_sck       <= 1'b0;
         r_cs        <= 1'b1;
         r_sdo       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_bit_cnt   <= '0;
         r_gap       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= 1'b0;
         if (w_accept) begin
            r_cs      <= 1'b0;
            r_sdo     <= cmd_data_i[WORD_SIZE-1];
            r_bit_cnt <= '0;
         end
         if (w_rise) begin
            r_sck <= 1'b1;
         end
         // Falling edge: present the next bit, which sits just below the current MSB.
         if (w_fall) begin
            r_sck     <= 1'b0;
            r_sdo     <= r_tx_shift[WORD_SIZE-2];
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         end
         if (w_hold_done) begin
            r_cs        <= 1'b1;
            r_sdo       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx_shift;
            r_gap       <= CS_GAP'(1);
         end
         // One-hot walk through the CS-high gap instead of a second counter.
         if (r_state == S_GAP) begin
            r_gap <= r_gap << 1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_tx_shift <= cmd_data_i;
      end else if (w_fall) begin
         r_tx_shift <= r_tx_shift << 1;
      end
      if (w_rise) begin
         r_rx_shift <= {r_rx_shift[WORD_SIZE-2:0], spi_sdi_i};
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE);
   assign busy_o      = (r_state != S_IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign spi_sck_o   = r_sck;
   assign spi_cs_o    = r_cs;
   assign spi_sdo_o   = r_sdo;

endmodule

// File: tb/tb_sobel_gcd_spi_master.sv
// Bench for sobel_gcd_spi_master: default instance plus a CLK_DIV=2/WORD_SIZE=8
// instance, each with a mode-0 bench slave and a response scoreboard.
module tb_sobel_gcd_spi_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // default-parameter instance
   logic        a_valid = 1'b0;
   logic [15:0] a_data  = '0;
   logic        a_ready, a_rsp_v, a_busy, a_sck, a_cs, a_sdo;
   logic [15:0] a_rsp;
   logic        a_sdi = 1'b0;

   sobel_gcd_spi_master u_dut_a (
      .clk_i       (clk),
      .reset_i     (rst),
      .cmd_valid_i (a_valid),
      .cmd_data_i  (a_data),
      .cmd_ready_o (a_ready),
      .rsp_valid_o (a_rsp_v),
      .rsp_data_o  (a_rsp),
      .busy_o      (a_busy),
      .spi_sck_o   (a_sck),
      .spi_cs_o    (a_cs),
      .spi_sdo_o   (a_sdo),
      .spi_sdi_i   (a_sdi)
   );

   // swept instance
   logic       b_valid = 1'b0;
   logic [7:0] b_data  = '0;
   logic       b_ready, b_rsp_v, b_busy, b_sck, b_cs, b_sdo;
   logic [7:0] b_rsp;
   logic       b_sdi = 1'b0;

   sobel_gcd_spi_master #(
      .WORD_SIZE (8),
      .CLK_DIV   (2),
      .CS_GAP    (4)
   ) u_dut_b (
      .clk_i       (clk),
      .reset_i     (rst),
      .cmd_valid_i (b_valid),
      .cmd_data_i  (b_data),
      .cmd_ready_o (b_ready),
      .rsp_valid_o (b_rsp_v),
      .rsp_data_o  (b_rsp),
      .busy_o      (b_busy),
      .spi_sck_o   (b_sck),
      .spi_cs_o    (b_cs),
      .spi_sdo_o   (b_sdo),
      .spi_sdi_i   (b_sdi)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // scoreboards and slave data
   logic [15:0] a_exp_q[$];
   logic [15:0] a_slv_q[$];
   logic [7:0]  b_exp_q[$];
   logic [7:0]  b_slv_word = 8'h3C;

   // instance A monitor / slave state
   logic        a_prev_cs = 1'b1, a_prev_sck = 1'b0, a_prev_rsp_v = 1'b0;
   logic [15:0] a_slv_sr = '0, a_mosi = '0, a_last_mosi = '0;
   int          a_cslo = 0, a_last_cslo = 0, a_cshi = 0, a_last_cshi = 0;
   int          a_rises = 0, a_last_rises = 0, a_rsp_cnt = 0, a_rsp_cyc = 0;
   int          a_sck_viol = 0, a_ready_viol = 0;

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (a_cs && a_prev_cs && (a_sck != a_prev_sck)) a_sck_viol++;
         if (!a_cs && a_ready) a_ready_viol++;
         if (!a_cs && a_prev_cs) begin
            a_last_cshi = a_cshi;
            a_cslo  = 0;
            a_mosi  = '0;
            a_rises = 0;
            a_slv_sr = (a_slv_q.size() > 0) ? a_slv_q.pop_front() : 16'h0000;
            a_sdi = a_slv_sr[15];
         end
         if (!a_cs) a_cslo++;
         else a_cshi = a_prev_cs ? a_cshi + 1 : 1;
         if (a_cs && !a_prev_cs) begin
            a_last_cslo  = a_cslo;
            a_last_mosi  = a_mosi;
            a_last_rises = a_rises;
         end
         if (!a_cs && a_sck && !a_prev_sck) begin
            a_rises++;
            a_mosi = {a_mosi[14:0], a_sdo};
         end
         if (!a_cs && !a_sck && a_prev_sck) begin
            a_slv_sr = a_slv_sr << 1;
            a_sdi = a_slv_sr[15];
         end
         if (a_rsp_v) begin
            a_rsp_cnt++;
            a_rsp_cyc = cyc;
            check("a_rsp_pulse_len", 32'(a_prev_rsp_v), 32'd0);
            check("a_rsp_cs_high", 32'(a_cs), 32'd1);
            check("a_rsp_queued", 32'(a_exp_q.size() > 0), 32'd1);
            if (a_exp_q.size() > 0) check("a_rsp_data", 32'(a_rsp), 32'(a_exp_q.pop_front()));
         end
         a_prev_cs = a_cs;
         a_prev_sck = a_sck;
         a_prev_rsp_v = a_rsp_v;
      end
   end

   // instance B monitor / slave state
   logic       b_prev_cs = 1'b1, b_prev_sck = 1'b0;
   logic [7:0] b_slv_sr = '0, b_mosi = '0, b_last_mosi = '0;
   int         b_cslo = 0, b_last_cslo = 0, b_rises = 0, b_last_rises = 0;
   int         b_hi = 0, b_last_hi = 0, b_rsp_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (!b_cs && b_prev_cs) begin
            b_cslo  = 0;
            b_mosi  = '0;
            b_rises = 0;
            b_slv_sr = b_slv_word;
            b_sdi = b_slv_sr[7];
         end
         if (!b_cs) b_cslo++;
         if (b_cs && !b_prev_cs) begin
            b_last_cslo  = b_cslo;
            b_last_mosi  = b_mosi;
            b_last_rises = b_rises;
         end
         if (b_sck) b_hi++;
         else if (b_prev_sck) begin
            b_last_hi = b_hi;
            b_hi = 0;
         end
         if (!b_cs && b_sck && !b_prev_sck) begin
            b_rises++;
            b_mosi = {b_mosi[6:0], b_sdo};
         end
         if (!b_cs && !b_sck && b_prev_sck) begin
            b_slv_sr = b_slv_sr << 1;
            b_sdi = b_slv_sr[7];
         end
         if (b_rsp_v) begin
            b_rsp_cnt++;
            check("b_rsp_queued", 32'(b_exp_q.size() > 0), 32'd1);
            if (b_exp_q.size() > 0) check("b_rsp_data", 32'(b_rsp), 32'(b_exp_q.pop_front()));
         end
         b_prev_cs = b_cs;
         b_prev_sck = b_sck;
      end
   end

   int a_acc_cyc = 0;

   task automatic send_a(input logic [15:0] d, input logic [15:0] slv, input bit exp_rsp);
      int k = 0;
      a_slv_q.push_back(slv);
      if (exp_rsp) a_exp_q.push_back(slv);
      a_valid = 1'b1;
      a_data  = d;
      while (!a_ready && k < 1000) begin
         step();
         k++;
      end
      check("a_accept_ready", 32'(a_ready), 32'd1);
      a_acc_cyc = cyc;
      step();
   endtask

   task automatic wait_a_rsp(input int n0, input string tag);
      int k = 0;
      while (a_rsp_cnt == n0 && k < 1000) begin
         step();
         k++;
      end
      check(tag, 32'(a_rsp_cnt > n0), 32'd1);
   endtask

   initial begin
      int n;
      int k;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      rst = 1'b1;
      repeat (3) step();
      check("rst_cs", 32'(a_cs), 32'd1);
      check("rst_sck", 32'(a_sck), 32'd0);
      check("rst_sdo", 32'(a_sdo), 32'd0);
      check("rst_ready", 32'(a_ready), 32'd1);
      check("rst_rsp_valid", 32'(a_rsp_v), 32'd0);
      check("rst_rsp_data", 32'(a_rsp), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_b_cs", 32'(b_cs), 32'd1);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (20) step();
      check("idle_sck_toggles", 32'(a_sck_viol), 32'd0);
      check("idle_sck_low", 32'(a_sck), 32'd0);

      // single write
      n = a_rsp_cnt;
      send_a(16'h1001, 16'h0000, 1'b1);
      a_valid = 1'b0;
      wait_a_rsp(n, "single_rsp_arrived");
      check("single_mosi", 32'(a_last_mosi), 32'h1001);
      check("single_rises", 32'(a_last_rises), 32'd16);
      check("single_cs_low", 32'(a_last_cslo), 32'd136);
      check("single_latency", 32'(a_rsp_cyc - a_acc_cyc), 32'd137);
      repeat (3) step();
      check("gap_busy_high", 32'(a_busy), 32'd1);
      step();
      check("gap_busy_dropped", 32'(a_busy), 32'd0);

      // full duplex
      n = a_rsp_cnt;
      send_a(16'h1300, 16'hA55A, 1'b1);
      a_valid = 1'b0;
      wait_a_rsp(n, "duplex_rsp_arrived");
      check("duplex_mosi", 32'(a_last_mosi), 32'h1300);
      repeat (10) step();
      check("duplex_rsp_hold", 32'(a_rsp), 32'hA55A);
      check("duplex_rsp_valid_low", 32'(a_rsp_v), 32'd0);

      // back-to-back with valid held; data changed mid-frame must not leak in
      n = a_rsp_cnt;
      send_a(16'hAA02, 16'h5A01, 1'b1);
      send_a(16'h1101, 16'h00FF, 1'b1);
      a_valid = 1'b0;
      check("b2b_first_mosi", 32'(a_last_mosi), 32'hAA02);
      check("b2b_first_cs_low", 32'(a_last_cslo), 32'd136);
      check("b2b_cs_gap", 32'(a_last_cshi), 32'd5);
      wait_a_rsp(n + 1, "b2b_second_rsp_arrived");
      check("b2b_second_mosi", 32'(a_last_mosi), 32'h1101);
      check("b2b_ready_in_frame", 32'(a_ready_viol), 32'd0);

      // reset mid-frame
      repeat (10) step();
      send_a(16'hC0DE, 16'hFFFF, 1'b0);
      a_valid = 1'b0;
      k = 0;
      while (a_rises < 7 && k < 1000) begin
         step();
         k++;
      end
      check("abort_reached_7_rises", 32'(a_rises), 32'd7);
      rst = 1'b1;
      step();
      check("abort_cs", 32'(a_cs), 32'd1);
      check("abort_sck", 32'(a_sck), 32'd0);
      check("abort_rsp_valid", 32'(a_rsp_v), 32'd0);
      check("abort_ready", 32'(a_ready), 32'd1);
      rst = 1'b0;
      n = a_rsp_cnt;
      repeat (20) step();
      check("abort_no_rsp", 32'(a_rsp_cnt), 32'(n));
      send_a(16'h1201, 16'h3C5A, 1'b1);
      a_valid = 1'b0;
      wait_a_rsp(n, "post_abort_rsp_arrived");
      check("post_abort_mosi", 32'(a_last_mosi), 32'h1201);
      check("post_abort_rises", 32'(a_last_rises), 32'd16);

      // parameter sweep instance
      n = b_rsp_cnt;
      b_exp_q.push_back(b_slv_word);
      b_valid = 1'b1;
      b_data  = 8'hC3;
      check("b_ready_before", 32'(b_ready), 32'd1);
      step();
      b_valid = 1'b0;
      b_data  = 8'h00;
      k = 0;
      while (b_rsp_cnt == n && k < 500) begin
         step();
         k++;
      end
      check("b_rsp_arrived", 32'(b_rsp_cnt > n), 32'd1);
      check("b_cs_low", 32'(b_last_cslo), 32'd36);
      check("b_mosi", 32'(b_last_mosi), 32'hC3);
      check("b_rises", 32'(b_last_rises), 32'd8);
      check("b_sck_high_len", 32'(b_last_hi), 32'd2);

      repeat (10) step();
      check("final_sck_toggles_cs_high", 32'(a_sck_viol), 32'd0);
      check("final_ready_in_frame", 32'(a_ready_viol), 32'd0);
      check("final_a_queue_empty", 32'(a_exp_q.size()), 32'd0);
      check("final_b_queue_empty", 32'(b_exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
